// File: rtl/bp_nonsynth_axil_nbf_sink_if.sv
// AXI-Lite bundle between the NBF loader (master) and the NBF sink (slave).
// All five channels live here; clock and reset stay plain ports on the modules.
interface bp_nonsynth_axil_nbf_sink_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [2:0]              awprot;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [2:0]              arprot;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic                    rready;
  logic [1:0]              rresp;

  modport master (
    output awaddr, awvalid, awprot, wdata, wvalid, wstrb, bready,
           araddr, arvalid, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wvalid, wstrb, bready,
           araddr, arvalid, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
  );
endinterface

// File: rtl/bp_nonsynth_axil_nbf_sink.sv
// AXI-Lite write slave that reassembles five 32-bit NBF flits into one command
// and hands it off on a valid/ready port; a read returns {fin, command count}.
module bp_nonsynth_axil_nbf_sink #(
  parameter int          S_AXIL_ADDR_WIDTH = 64,
  parameter int          S_AXIL_DATA_WIDTH = 32,
  parameter logic [63:0] nbf_host_addr_p   = 64'h0,
  parameter logic [7:0]  nbf_finish_op_p   = 8'hFF
) (
  input  logic                          s_axil_aclk,
  input  logic                          s_axil_aresetn,
  bp_nonsynth_axil_nbf_sink_if.slave    s_axil,
  output logic [7:0]                    nbf_opcode_o,
  output logic [63:0]                   nbf_addr_o,
  output logic [63:0]                   nbf_data_o,
  output logic                          nbf_v_o,
  input  logic                          nbf_ready_i,
  output logic                          fin_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic        run_reg;
  logic        aw_full_reg;
  logic        aw_ok_reg;
  logic        w_full_reg;
  logic [31:0] w_data_reg;
  logic [3:0]  w_strb_reg;
  logic [2:0]  flit_cnt_reg;
  logic [31:0] flit_reg [4];
  logic        bvalid_reg;
  logic [1:0]  bresp_reg;
  logic        nbf_v_reg;
  logic [7:0]  nbf_opcode_reg;
  logic [63:0] nbf_addr_reg;
  logic [63:0] nbf_data_reg;
  logic [30:0] cmd_count_reg;
  logic        fin_reg;
  logic        rvalid_reg;
  logic [31:0] rdata_reg;

  logic stall;
  logic commit;
  logic commit_ok;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  // A pending command or an unaccepted B response freezes the whole write path.
  assign stall     = nbf_v_reg | (bvalid_reg & ~s_axil.bready);
  assign commit    = aw_full_reg & w_full_reg & ~stall;
  assign commit_ok = commit & aw_ok_reg & (w_strb_reg == 4'hF);

  assign s_axil.awready = run_reg & ~aw_full_reg & ~stall;
  assign s_axil.wready  = run_reg & ~w_full_reg & ~stall;
  assign s_axil.arready = run_reg & ~rvalid_reg;
  assign aw_hs = s_axil.awvalid & s_axil.awready;
  assign w_hs  = s_axil.wvalid & s_axil.wready;
  assign ar_hs = s_axil.arvalid & s_axil.arready;

  assign s_axil.bvalid = bvalid_reg;
  assign s_axil.bresp  = bresp_reg;
  assign s_axil.rvalid = rvalid_reg;
  assign s_axil.rdata  = rdata_reg;
  assign s_axil.rresp  = RESP_OKAY;

  assign nbf_opcode_o = nbf_opcode_reg;
  assign nbf_addr_o   = nbf_addr_reg;
  assign nbf_data_o   = nbf_data_reg;
  assign nbf_v_o      = nbf_v_reg;
  assign fin_o        = fin_reg;

  logic unused_inputs;
  assign unused_inputs = ^{s_axil.awprot, s_axil.arprot, s_axil.araddr};

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      run_reg     <= 1'b0;
      aw_full_reg <= 1'b0;
      aw_ok_reg   <= 1'b0;
      w_full_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      run_reg <= 1'b1;
      // The address is reduced to an accept flag at capture; nothing else needs it.
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_ok_reg   <= (s_axil.awaddr == nbf_host_addr_p[S_AXIL_ADDR_WIDTH-1:0]);
      end else if (commit) begin
        aw_full_reg <= 1'b0;
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= s_axil.wdata[31:0];
        w_strb_reg <= s_axil.wstrb[3:0];
      end else if (commit) begin
        w_full_reg <= 1'b0;
      end
      if (commit) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= commit_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil.bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  // Flits 0..3 are staged; flit 4 carries the opcode and completes the command.
  for (genvar gi = 0; gi < 4; gi++) begin : g_flit
    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
        flit_reg[gi] <= '0;
      end else if (commit_ok && (flit_cnt_reg == 3'(gi))) begin
        flit_reg[gi] <= w_data_reg;
      end
    end
  end

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      flit_cnt_reg   <= '0;
      nbf_v_reg      <= 1'b0;
      nbf_opcode_reg <= '0;
      nbf_addr_reg   <= '0;
      nbf_data_reg   <= '0;
      cmd_count_reg  <= '0;
      fin_reg        <= 1'b0;
    end else begin
      if (commit_ok) begin
        if (flit_cnt_reg == 3'd4) begin
          flit_cnt_reg   <= '0;
          nbf_v_reg      <= 1'b1;
          nbf_opcode_reg <= w_data_reg[7:0];
          nbf_addr_reg   <= {flit_reg[3], flit_reg[2]};
          nbf_data_reg   <= {flit_reg[1], flit_reg[0]};
        end else begin
          flit_cnt_reg <= flit_cnt_reg + 3'd1;
        end
      end
      if (nbf_v_reg && nbf_ready_i) begin
        nbf_v_reg     <= 1'b0;
        cmd_count_reg <= cmd_count_reg + 31'd1;
        if (nbf_opcode_reg == nbf_finish_op_p) begin
          fin_reg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= {fin_reg, cmd_count_reg};
    end else if (s_axil.rready) begin
      rvalid_reg <= 1'b0;
    end
  end

endmodule
